// File: rtl/station_cmd_ctrl_if.sv
// Command and barcode-ID handshakes between the host/reader side (master)
// and the station sequencer (slave).
interface station_cmd_ctrl_if;
    logic [7:0] cmd;
    logic       cmd_rdy;
    logic       clr_cmd_rdy;
    logic [7:0] ID;
    logic       ID_vld;
    logic       clr_ID_vld;

    modport master (
        output cmd, cmd_rdy, ID, ID_vld,
        input  clr_cmd_rdy, clr_ID_vld
    );

    modport slave (
        input  cmd, cmd_rdy, ID, ID_vld,
        output clr_cmd_rdy, clr_ID_vld
    );
endinterface

// File: rtl/station_cmd_ctrl.sv
// Station sequencer: consumes host commands and barcode IDs, tracks the
// destination station, drives go while in transit and buzzes when obstructed.
module station_cmd_ctrl #(
    parameter int BUZZ_DIV = 12500,
    parameter int BUZZ_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    station_cmd_ctrl_if.slave         bus,
    input  logic                      OK2Move,
    output logic                      go,
    output logic                      in_transit,
    output logic                      buzz,
    output logic                      buzz_n
);

    typedef enum logic [0:0] {IDLE, MOVING} state_t;

    localparam logic [1:0]        OP_STOP   = 2'b00;
    localparam logic [1:0]        OP_GO     = 2'b01;
    localparam logic [BUZZ_W-1:0] BUZZ_LAST = BUZZ_W'(BUZZ_DIV - 1);

    state_t            state_reg, state_next;
    logic [5:0]        dest_reg, dest_next;
    logic              in_transit_reg, in_transit_next;
    logic [BUZZ_W-1:0] buzz_cnt_reg, buzz_cnt_next;
    logic              buzz_reg, buzz_next;
    logic              clr_cmd, clr_id;
    logic              obstructed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            dest_reg       <= 6'h00;
            in_transit_reg <= 1'b0;
            buzz_cnt_reg   <= '0;
            buzz_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            dest_reg       <= dest_next;
            in_transit_reg <= in_transit_next;
            buzz_cnt_reg   <= buzz_cnt_next;
            buzz_reg       <= buzz_next;
        end
    end

    // Commands always win over IDs; a deferred ID is seen again next cycle.
    always_comb begin
        state_next      = state_reg;
        dest_next       = dest_reg;
        in_transit_next = in_transit_reg;
        clr_cmd         = 1'b0;
        clr_id          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.cmd_rdy) begin
                    clr_cmd = 1'b1;
                    if (bus.cmd[7:6] == OP_GO) begin
                        dest_next       = bus.cmd[5:0];
                        in_transit_next = 1'b1;
                        state_next      = MOVING;
                    end
                end else if (bus.ID_vld) begin
                    clr_id = 1'b1;
                end
            end
            MOVING: begin
                if (bus.cmd_rdy) begin
                    clr_cmd = 1'b1;
                    if (bus.cmd[7:6] == OP_GO) begin
                        dest_next = bus.cmd[5:0];
                    end else if (bus.cmd[7:6] == OP_STOP) begin
                        in_transit_next = 1'b0;
                        state_next      = IDLE;
                    end
                end else if (bus.ID_vld) begin
                    clr_id = 1'b1;
                    if ((bus.ID[7:6] == 2'b00) && (bus.ID[5:0] == dest_reg)) begin
                        in_transit_next = 1'b0;
                        state_next      = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign obstructed = in_transit_reg & ~OK2Move;

    always_comb begin
        buzz_cnt_next = '0;
        buzz_next     = 1'b0;
        if (obstructed) begin
            if (buzz_cnt_reg == BUZZ_LAST) begin
                buzz_cnt_next = '0;
                buzz_next     = ~buzz_reg;
            end else begin
                buzz_cnt_next = buzz_cnt_reg + 1'b1;
                buzz_next     = buzz_reg;
            end
        end
    end

    // Reset also masks the consume pulses so a held valid is not cleared early.
    assign bus.clr_cmd_rdy = clr_cmd & rst_n;
    assign bus.clr_ID_vld  = clr_id & rst_n;
    assign in_transit      = in_transit_reg;
    assign go              = in_transit_reg & OK2Move;
    assign buzz            = buzz_reg;
    assign buzz_n          = ~buzz_reg;

endmodule
